pattern_gen: RTL and testbench

//   Free-running video test-pattern source for the SDI->MIPI converter datapath.

---
 rtl/pattern_gen_pkg.sv | 49 ++++
 rtl/pattern_timing.sv | 44 ++++
 rtl/pattern_gen.sv | 79 +++++++
 tb/tb_pattern_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pattern_gen_pkg.sv
// Shared constants for the colour-bar test-pattern source: default 1080p raster
// timing and the BT.709 limited-range bar colour table.
package pattern_gen_pkg;

  localparam int H_ACTIVE_DEF      = 1920;
  localparam int H_FRONT_PORCH_DEF = 88;
  localparam int H_SYNC_DEF        = 44;
  localparam int H_BACK_PORCH_DEF  = 148;
  localparam int V_ACTIVE_DEF      = 1080;
  localparam int V_FRONT_PORCH_DEF = 4;
  localparam int V_SYNC_DEF        = 5;
  localparam int V_BACK_PORCH_DEF  = 36;

  localparam int CNT_W  = 12;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    BAR_WHITE,
    BAR_YELLOW,
    BAR_CYAN,
    BAR_GREEN,
    BAR_MAGENTA,
    BAR_RED,
    BAR_BLUE,
    BAR_BLACK
  } bar_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycbcr_t;

  function automatic ycbcr_t bar_color(input bar_t bar);
    ycbcr_t c;
    case (bar)
      BAR_WHITE:   c = '{y: 8'd235, cb: 8'd128, cr: 8'd128};
      BAR_YELLOW:  c = '{y: 8'd219, cb: 8'd16,  cr: 8'd138};
      BAR_CYAN:    c = '{y: 8'd188, cb: 8'd154, cr: 8'd16};
      BAR_GREEN:   c = '{y: 8'd173, cb: 8'd42,  cr: 8'd26};
      BAR_MAGENTA: c = '{y: 8'd78,  cb: 8'd214, cr: 8'd230};
      BAR_RED:     c = '{y: 8'd63,  cb: 8'd102, cr: 8'd240};
      BAR_BLUE:    c = '{y: 8'd32,  cb: 8'd240, cr: 8'd118};
      default:     c = '{y: 8'd16,  cb: 8'd128, cr: 8'd128};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pattern_timing.sv
// Raster position counters (h = pixel, v = line) plus the frame/line active
// decode for the current position. Active region comes first in each line/frame.
module pattern_timing
  import pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE      = H_ACTIVE_DEF,
  parameter int H_FRONT_PORCH = H_FRONT_PORCH_DEF,
  parameter int H_SYNC        = H_SYNC_DEF,
  parameter int H_BACK_PORCH  = H_BACK_PORCH_DEF,
  parameter int V_ACTIVE      = V_ACTIVE_DEF,
  parameter int V_FRONT_PORCH = V_FRONT_PORCH_DEF,
  parameter int V_SYNC        = V_SYNC_DEF,
  parameter int V_BACK_PORCH  = V_BACK_PORCH_DEF
) (
  input  logic             pix_clk,
  input  logic             pix_rst,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             frame_act,
  output logic             line_act
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Free-running raster: pixel counter wraps into the line counter, which wraps per frame.
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign frame_act = (v < CNT_W'(V_ACTIVE));
  assign line_act  = frame_act && (h < CNT_W'(H_ACTIVE));

endmodule

// File: rtl/pattern_gen.sv
// Eight-bar YCbCr 4:2:2 colour-bar source. Every output is registered from the
// same raster position, so pixcnt/linecnt always describe the fv/lv/data beside them.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE      = H_ACTIVE_DEF,
  parameter int H_FRONT_PORCH = H_FRONT_PORCH_DEF,
  parameter int H_SYNC        = H_SYNC_DEF,
  parameter int H_BACK_PORCH  = H_BACK_PORCH_DEF,
  parameter int V_ACTIVE      = V_ACTIVE_DEF,
  parameter int V_FRONT_PORCH = V_FRONT_PORCH_DEF,
  parameter int V_SYNC        = V_SYNC_DEF,
  parameter int V_BACK_PORCH  = V_BACK_PORCH_DEF
) (
  input  logic              pix_clk,
  input  logic              pix_rst,
  output logic              fv,
  output logic              lv,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  linecnt,
  output logic [CNT_W-1:0]  pixcnt
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic             frame_act;
  logic             line_act;
  bar_t             bar;
  ycbcr_t           color;
  logic [7:0]       chroma;

  pattern_timing #(
    .H_ACTIVE      (H_ACTIVE),
    .H_FRONT_PORCH (H_FRONT_PORCH),
    .H_SYNC        (H_SYNC),
    .H_BACK_PORCH  (H_BACK_PORCH),
    .V_ACTIVE      (V_ACTIVE),
    .V_FRONT_PORCH (V_FRONT_PORCH),
    .V_SYNC        (V_SYNC),
    .V_BACK_PORCH  (V_BACK_PORCH)
  ) u_timing (
    .pix_clk   (pix_clk),
    .pix_rst   (pix_rst),
    .h         (h),
    .v         (v),
    .frame_act (frame_act),
    .line_act  (line_act)
  );

  // Bar index from a ladder of constant thresholds; pixels past 7*BAR_W all land in bar 7.
  always_comb begin
    bar = BAR_WHITE;
    for (int k = 1; k < 8; k++) begin
      if (h >= CNT_W'(k * BAR_W)) bar = bar_t'(3'(k));
    end
  end

  assign color  = bar_color(bar);
  assign chroma = h[0] ? color.cr : color.cb;

  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      fv      <= 1'b0;
      lv      <= 1'b0;
      data    <= '0;
      linecnt <= '0;
      pixcnt  <= '0;
    end else begin
      fv      <= frame_act;
      lv      <= line_act;
      data    <= line_act ? {chroma, color.y} : '0;
      linecnt <= v;
      pixcnt  <= h;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench: a 1080p instance for reset, line timing and bar edges, and a
// tiny-raster instance for multi-frame, blanking, bar clamping and mid-frame reset.
module tb_pattern_gen;

  logic        pix_clk = 1'b0;
  logic        rstA;
  logic        rstB;
  logic        fvA, lvA, fvB, lvB;
  logic [15:0] dataA, dataB;
  logic [11:0] linecntA, pixcntA, linecntB, pixcntB;

  int total = 0;
  int bad   = 0;

  localparam int SH_ACT = 20;
  localparam int SV_ACT = 6;
  localparam int SH_TOT = 28;
  localparam int SV_TOT = 10;
  localparam int SFRAME = SH_TOT * SV_TOT;

  logic [15:0] frameRef [SFRAME];

  always #5 pix_clk = ~pix_clk;

  pattern_gen dutA (
    .pix_clk (pix_clk),
    .pix_rst (rstA),
    .fv      (fvA),
    .lv      (lvA),
    .data    (dataA),
    .linecnt (linecntA),
    .pixcnt  (pixcntA)
  );

  pattern_gen #(
    .H_ACTIVE      (SH_ACT),
    .H_FRONT_PORCH (2),
    .H_SYNC        (2),
    .H_BACK_PORCH  (4),
    .V_ACTIVE      (SV_ACT),
    .V_FRONT_PORCH (1),
    .V_SYNC        (1),
    .V_BACK_PORCH  (2)
  ) dutB (
    .pix_clk (pix_clk),
    .pix_rst (rstB),
    .fv      (fvB),
    .lv      (lvB),
    .data    (dataB),
    .linecnt (linecntB),
    .pixcnt  (pixcntB)
  );

  // Reference pixel value using plain division and a clamp.
  function automatic logic [15:0] expData(int h, int v, int hAct, int vAct);
    int b;
    logic [7:0] y, cb, cr;
    if (v >= vAct || h >= hAct) return 16'h0000;
    b = h / (hAct / 8);
    if (b > 7) b = 7;
    case (b)
      0:       begin y = 8'd235; cb = 8'd128; cr = 8'd128; end
      1:       begin y = 8'd219; cb = 8'd16;  cr = 8'd138; end
      2:       begin y = 8'd188; cb = 8'd154; cr = 8'd16;  end
      3:       begin y = 8'd173; cb = 8'd42;  cr = 8'd26;  end
      4:       begin y = 8'd78;  cb = 8'd214; cr = 8'd230; end
      5:       begin y = 8'd63;  cb = 8'd102; cr = 8'd240; end
      6:       begin y = 8'd32;  cb = 8'd240; cr = 8'd118; end
      default: begin y = 8'd16;  cb = 8'd128; cr = 8'd128; end
    endcase
    return {(h % 2 == 1) ? cr : cb, y};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge pix_clk);
      @(negedge pix_clk);
    end
  endtask

  initial begin
    int  lvHi, lvLo, blankErr, frameErr;
    int  fvHi [3];
    bit  seqOk, found;

    rstA = 1'b1;
    rstB = 1'b1;
    applyStimulus(2);
    checkOutput("rstA_fv",      16'(fvA),      16'd0);
    checkOutput("rstA_lv",      16'(lvA),      16'd0);
    checkOutput("rstA_data",    dataA,         16'h0000);
    checkOutput("rstA_pixcnt",  16'(pixcntA),  16'd0);
    checkOutput("rstA_linecnt", 16'(linecntA), 16'd0);

    rstA = 1'b0;
    applyStimulus(1);
    checkOutput("firstA_pixcnt",  16'(pixcntA),  16'd0);
    checkOutput("firstA_linecnt", 16'(linecntA), 16'd0);
    checkOutput("firstA_fv",      16'(fvA),      16'd1);
    checkOutput("firstA_lv",      16'(lvA),      16'd1);
    checkOutput("firstA_data",    dataA,         16'h80EB);

    lvHi  = 0;
    lvLo  = 0;
    seqOk = 1'b1;
    for (int i = 0; i < 2200; i++) begin
      if (i > 0) applyStimulus(1);
      if (pixcntA !== 12'(i) || linecntA !== 12'd0 || fvA !== 1'b1 ||
          dataA !== expData(i, 0, 1920, 1080)) seqOk = 1'b0;
      if (lvA) lvHi++;
      else     lvLo++;
      if (i == 239)  checkOutput("bar0_last_px239",  dataA, 16'h80EB);
      if (i == 240)  checkOutput("bar1_first_px240", dataA, 16'h10DB);
      if (i == 1919) checkOutput("bar7_last_px1919", dataA, 16'h8010);
      if (i == 1920) checkOutput("hblank_px1920_lv", 16'(lvA), 16'd0);
    end
    checkOutput("line0_seq",     16'(seqOk), 16'd1);
    checkOutput("line0_lv_high", 16'(lvHi),  16'd1920);
    checkOutput("line0_lv_low",  16'(lvLo),  16'd280);
    applyStimulus(1);
    checkOutput("line1_pixcnt",  16'(pixcntA),  16'd0);
    checkOutput("line1_linecnt", 16'(linecntA), 16'd1);
    checkOutput("line1_lv",      16'(lvA),      16'd1);

    rstB = 1'b0;
    applyStimulus(1);
    seqOk    = 1'b1;
    blankErr = 0;
    frameErr = 0;
    fvHi     = '{0, 0, 0};
    for (int n = 0; n < 3 * SFRAME; n++) begin
      int eh, ev, idx;
      if (n > 0) applyStimulus(1);
      idx = n % SFRAME;
      eh  = n % SH_TOT;
      ev  = (n / SH_TOT) % SV_TOT;
      if (pixcntB !== 12'(eh) || linecntB !== 12'(ev) ||
          fvB !== (ev < SV_ACT) || lvB !== (ev < SV_ACT && eh < SH_ACT) ||
          dataB !== expData(eh, ev, SH_ACT, SV_ACT)) seqOk = 1'b0;
      if (!lvB && dataB !== 16'h0000) blankErr++;
      if (fvB) fvHi[n / SFRAME]++;
      if (n < SFRAME) frameRef[idx] = dataB;
      else if (dataB !== frameRef[idx]) frameErr++;
      if (n == 13)  checkOutput("small_bar6_px13",  dataB, 16'h7620);
      if (n == 14)  checkOutput("small_bar7_px14",  dataB, 16'h8010);
      if (n == 19)  checkOutput("small_clamp_px19", dataB, 16'h8010);
      if (n == SFRAME - 1) begin
        checkOutput("small_last_pixcnt",  16'(pixcntB),  16'd27);
        checkOutput("small_last_linecnt", 16'(linecntB), 16'd9);
        checkOutput("small_last_fv",      16'(fvB),      16'd0);
      end
      if (n == SFRAME) begin
        checkOutput("small_wrap_pixcnt",  16'(pixcntB),  16'd0);
        checkOutput("small_wrap_linecnt", 16'(linecntB), 16'd0);
        checkOutput("small_wrap_fv",      16'(fvB),      16'd1);
      end
    end
    checkOutput("small_raster_seq", 16'(seqOk),    16'd1);
    checkOutput("small_blanking",   16'(blankErr), 16'd0);
    checkOutput("small_frames_eq",  16'(frameErr), 16'd0);
    for (int f = 0; f < 3; f++)
      checkOutput($sformatf("small_fv_high_f%0d", f), 16'(fvHi[f]), 16'(SV_ACT * SH_TOT));

    found = 1'b0;
    for (int k = 0; k < 2 * SFRAME && !found; k++) begin
      applyStimulus(1);
      if (linecntB == 12'd3 && pixcntB == 12'd10) found = 1'b1;
    end
    checkOutput("mid_wait_found", 16'(found), 16'd1);
    rstB = 1'b1;
    applyStimulus(1);
    checkOutput("mid_rst_fv",      16'(fvB),      16'd0);
    checkOutput("mid_rst_lv",      16'(lvB),      16'd0);
    checkOutput("mid_rst_data",    dataB,         16'h0000);
    checkOutput("mid_rst_pixcnt",  16'(pixcntB),  16'd0);
    checkOutput("mid_rst_linecnt", 16'(linecntB), 16'd0);
    rstB = 1'b0;
    applyStimulus(1);
    checkOutput("restart_pixcnt",  16'(pixcntB),  16'd0);
    checkOutput("restart_linecnt", 16'(linecntB), 16'd0);
    checkOutput("restart_fv",      16'(fvB),      16'd1);
    checkOutput("restart_data",    dataB,         16'h80EB);
    applyStimulus(2);
    checkOutput("restart_px2_pixcnt", 16'(pixcntB), 16'd2);
    checkOutput("restart_px2_data",   dataB,        16'h10DB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
